// File: rtl/ysyx_22041071_div_pkg.sv
// Shared constants, state encoding and helpers for the iterative divider.
package ysyx_22041071_div_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  localparam logic [CNT_W-1:0] ITER_D = 7'd64;
  localparam logic [CNT_W-1:0] ITER_W = 7'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22041071_div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit, trial-subtract the divisor.
module ysyx_22041071_div_step
  import ysyx_22041071_div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            shift_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The partial remainder stays below the divisor, so bit XLEN of the
  // 65-bit difference is set exactly when the subtraction would go negative.
  assign shifted  = {rem, shift_in};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[XLEN];
  assign rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ysyx_22041071_div.sv
// Multi-cycle restoring divider, signed/unsigned, 64-bit or 32-bit (divw) operations.
module ysyx_22041071_div
  import ysyx_22041071_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_r, quo_r, dsr_r;
  logic             w_r, neg_q_r, neg_r_r, spec_r;

  logic [XLEN-1:0]  a_ext, b_ext, a_abs, b_abs;
  logic             a_neg, b_neg;
  logic             is_zero, is_ovf, special;
  logic [XLEN-1:0]  q_spec, r_spec;
  logic             accept;

  logic [XLEN-1:0]  rem_next;
  logic             q_bit;

  logic [XLEN-1:0]  q_fix, r_fix, q_res, r_res;

  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (divw) begin
      a_ext = div_signed ? sext32(dividend[31:0]) : {32'b0, dividend[31:0]};
      b_ext = div_signed ? sext32(divisor[31:0])  : {32'b0, divisor[31:0]};
    end
    a_neg = div_signed & a_ext[XLEN-1];
    b_neg = div_signed & b_ext[XLEN-1];
    a_abs = a_neg ? -a_ext : a_ext;
    b_abs = b_neg ? -b_ext : b_ext;

    is_zero = divw ? (divisor[31:0] == '0) : (divisor == '0);
    is_ovf  = div_signed & (divw ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == '1)
                                 : (dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1));
    special = is_zero | is_ovf;

    // Both corner cases report the operation-width dividend, sign-extended for divw.
    r_spec = divw ? sext32(dividend[31:0]) : dividend;
    q_spec = is_zero ? '1 : r_spec;
    if (is_ovf && !is_zero) r_spec = '0;
  end

  assign accept = (state == IDLE) && div_valid && !flush;

  ysyx_22041071_div_step u_step (
    .rem      (rem_r),
    .shift_in (quo_r[XLEN-1]),
    .divisor  (dsr_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (div_valid) state_next = special ? DONE : CALC;
        CALC:    if (cnt == 7'd1) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dsr_r   <= '0;
      w_r     <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      spec_r  <= 1'b0;
    end else if (accept) begin
      cnt     <= divw ? ITER_W : ITER_D;
      dsr_r   <= b_abs;
      w_r     <= divw;
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
      spec_r  <= special;
      if (special) begin
        rem_r <= r_spec;
        quo_r <= q_spec;
      end else begin
        rem_r <= '0;
        // 32-bit dividends start in the top half so the MSB shift-out order matches.
        quo_r <= divw ? {a_abs[31:0], 32'b0} : a_abs;
      end
    end else if (state == CALC) begin
      cnt   <= cnt - 7'd1;
      rem_r <= rem_next;
      quo_r <= {quo_r[XLEN-2:0], q_bit};
    end
  end

  always_comb begin
    q_fix = neg_q_r ? -quo_r : quo_r;
    r_fix = neg_r_r ? -rem_r : rem_r;
    if (w_r) begin
      q_fix = sext32(q_fix[31:0]);
      r_fix = sext32(r_fix[31:0]);
    end
    q_res = spec_r ? quo_r : q_fix;
    r_res = spec_r ? rem_r : r_fix;

    div_ready = (state == IDLE);
    out_valid = (state == DONE) && !flush;
    quotient  = out_valid ? q_res : '0;
    remainder = out_valid ? r_res : '0;
  end

endmodule

// File: tb/tb_ysyx_22041071_div.sv
// Self-checking bench: directed table, random ops against an arithmetic model, flush/reset sequences.
module tb_ysyx_22041071_div;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, divw, div_signed;
  logic [63:0] dividend, divisor;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_22041071_div dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [31:0] q32, r32;
    if (!w) begin
      lat = 65;
      if (b == 64'd0) begin
        q = '1; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; lat = 1;
      end else if (s) begin
        longint sa, sb;
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
      end else begin
        q = a / b; r = a % b;
      end
    end else begin
      lat = 33;
      if (b[31:0] == 32'd0) begin
        q32 = '1; r32 = a[31:0]; lat = 1;
      end else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == '1) begin
        q32 = a[31:0]; r32 = '0; lat = 1;
      end else if (s) begin
        int sa, sb;
        sa = a[31:0]; sb = b[31:0];
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end
  endfunction

  // Accept one operation at a negedge (cycle 0) and watch cycles 1..lat+1.
  task automatic run_op(input string tag, input bit w, input bit s, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                        input int lat);
    int          first, hits;
    logic [63:0] cq, cr;
    logic        idle_zero, ready_after;
    first = 0; hits = 0; cq = 64'hDEAD_BEEF_DEAD_BEEF; cr = 64'hDEAD_BEEF_DEAD_BEEF;
    idle_zero = 1'b1; ready_after = 1'b0;
    @(negedge clk);
    chk({tag, " ready"}, {63'd0, div_ready}, 64'd1);
    div_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        div_valid = 1'b0; divw = ~w; div_signed = ~s;
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
      end
      if (out_valid) begin
        hits++;
        if (first == 0) begin first = c; cq = quotient; cr = remainder; end
      end else if (quotient !== 64'd0 || remainder !== 64'd0) begin
        idle_zero = 1'b0;
      end
      if (c == lat + 1) ready_after = div_ready;
    end
    chk({tag, " valid_cycle"}, 64'(first), 64'(lat));
    chk({tag, " valid_count"}, 64'(hits), 64'd1);
    chk({tag, " quotient"}, cq, eq);
    chk({tag, " remainder"}, cr, er);
    chk({tag, " zero_when_idle"}, {63'd0, idle_zero}, 64'd1);
    chk({tag, " ready_after"}, {63'd0, ready_after}, 64'd1);
  endtask

  task automatic abort_op(input bit use_rst);
    int hits;
    string tag;
    tag = use_rst ? "rst_c10" : "flush_c10";
    hits = 0;
    @(negedge clk);
    div_valid = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) div_valid = 1'b0;
      if (out_valid) hits++;
    end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    chk({tag, " ready_c11"}, {63'd0, div_ready}, 64'd1);
    chk({tag, " valid_c11"}, {63'd0, out_valid}, 64'd0);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk({tag, " no_valid"}, 64'(hits), 64'd0);
    run_op({tag, " retry"}, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
  endtask

  initial begin
    logic [63:0] a, b, eq, er;
    int lat, mode;
    bit w, s;

    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", {63'd0, div_ready}, 64'd1);
    chk("reset valid", {63'd0, out_valid}, 64'd0);
    chk("reset quotient", quotient, 64'd0);
    chk("reset remainder", remainder, 64'd0);

    vecs[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
    vecs[1]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[2]  = '{1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
    vecs[3]  = '{1'b0, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
    vecs[4]  = '{1'b1, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
    vecs[5]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd0, 1};
    vecs[6]  = '{1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33};
    vecs[7]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
    vecs[8]  = '{1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[9]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
    vecs[10] = '{1'b0, 1'b0, 64'd7, 64'd100, 64'd0, 64'd7, 65};
    vecs[11] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'h8000_0000_0000_0000, 65};

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].lat);

    abort_op(1'b0);
    abort_op(1'b1);

    // flush together with div_valid in IDLE: nothing may be accepted
    @(negedge clk);
    div_valid = 1'b1; flush = 1'b1; dividend = 64'd100; divisor = 64'd7; divw = 1'b0;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_valid ready", {63'd0, div_ready}, 64'd1);
    @(negedge clk);
    chk("flush_vs_valid ready2", {63'd0, div_ready}, 64'd1);

    // flush during the DONE cycle suppresses out_valid
    @(negedge clk);
    div_valid = 1'b1; divw = 1'b1; div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) div_valid = 1'b0;
    end
    chk("done_flush valid_before", {63'd0, out_valid}, 64'd1);
    flush = 1'b1;
    #1;
    chk("done_flush valid_during", {63'd0, out_valid}, 64'd0);
    chk("done_flush quotient_during", quotient, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush ready_after", {63'd0, div_ready}, 64'd1);
    chk("done_flush valid_after", {63'd0, out_valid}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      mode = $urandom_range(0, 4);
      case (mode)
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(1, 15));
        2:       b = 64'd0;
        3:       b = '1;
        default: b = {32'($urandom), 32'($urandom_range(1, 1000))};
      endcase
      model(w, s, a, b, eq, er, lat);
      run_op($sformatf("rand%0d", i), w, s, a, b, eq, er, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
